// File: rtl/mx_alu_181.sv
// 8-bit 74181-style ALU: opcode decode ROM, P/G carry chain, registered result and status.
// All outputs load on a rising clk while cs_n is low; rst clears them asynchronously.
module mx_alu_181 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] f,
  output logic       x,
  output logic       y,
  output logic       a_b,
  output logic       cn4_n,
  output logic       cn8_n
);

  logic [3:0] s;
  logic       m;
  logic       cn_n;
  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic [8:0] cz;
  logic [7:0] f_nxt;

  always_comb begin
    s    = '0;
    m    = 1'b0;
    cn_n = 1'b1;
    case (opcode)
      4'h0: begin s = 4'b1001; m = 1'b0; cn_n = 1'b1; end
      4'h1: begin s = 4'b1001; m = 1'b0; cn_n = 1'b0; end
      4'h2: begin s = 4'b0110; m = 1'b0; cn_n = 1'b0; end
      4'h3: begin s = 4'b0110; m = 1'b0; cn_n = 1'b1; end
      4'h4: begin s = 4'b0000; m = 1'b0; cn_n = 1'b0; end
      4'h5: begin s = 4'b1111; m = 1'b0; cn_n = 1'b1; end
      4'h6: begin s = 4'b1100; m = 1'b0; cn_n = 1'b1; end
      4'h7: begin s = 4'b1111; m = 1'b1; end
      4'h8: begin s = 4'b0000; m = 1'b1; end
      4'h9: begin s = 4'b1011; m = 1'b1; end
      4'hA: begin s = 4'b1110; m = 1'b1; end
      4'hB: begin s = 4'b0110; m = 1'b1; end
      4'hC: begin s = 4'b0100; m = 1'b1; end
      4'hD: begin s = 4'b0001; m = 1'b1; end
      4'hE: begin s = 4'b1001; m = 1'b1; end
      default: begin s = 4'b1010; m = 1'b1; end
    endcase
  end

  // cz is the same chain forced to cin=0; it feeds the group-generate flag
  always_comb begin
    p     = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    g     = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
    c     = '0;
    cz    = '0;
    c[0]  = ~cn_n;
    for (int unsigned i = 0; i < 8; i++) begin
      c[i+1]  = g[i] | (p[i] & c[i]);
      cz[i+1] = g[i] | (p[i] & cz[i]);
    end
    f_nxt = m ? ~(p ^ g) : (p ^ g ^ c[7:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f     <= '0;
      x     <= 1'b1;
      y     <= 1'b1;
      a_b   <= 1'b0;
      cn4_n <= 1'b1;
      cn8_n <= 1'b1;
    end else if (!cs_n) begin
      f     <= f_nxt;
      x     <= ~(&p);
      y     <= ~cz[8];
      a_b   <= &f_nxt;
      cn4_n <= ~c[4];
      cn8_n <= ~c[8];
    end
  end

endmodule

// File: tb/tb_mx_alu_181.sv
// Bench for mx_alu_181: arithmetic-level reference model checked every cycle,
// plus hand-computed literal vectors for the key operations, hold and reset.
module tb_mx_alu_181;

  logic       clk;
  logic       rst;
  logic       cs_n;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] f;
  logic       x, y, a_b, cn4_n, cn8_n;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [7:0] ef;
  logic       ex, ey, eab, ec4n, ec8n;
  logic [7:0] mf;
  logic       mx, my, mab, mc4n, mc8n;

  mx_alu_181 dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .opcode(opcode), .a(a), .b(b),
    .f(f), .x(x), .y(y), .a_b(a_b), .cn4_n(cn4_n), .cn8_n(cn8_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: sums done with integer addition, not a bit-serial chain
  function automatic void model(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                                output logic [7:0] fo, output logic xo, output logic yo,
                                output logic abo, output logic c4no, output logic c8no);
    logic [3:0] sv;
    logic       mv;
    logic       cin;
    logic [7:0] pv, gv;
    logic [8:0] sum, sum0;
    logic [4:0] lo;
    case (op)
      4'h0: begin sv = 4'b1001; mv = 0; cin = 0; end
      4'h1: begin sv = 4'b1001; mv = 0; cin = 1; end
      4'h2: begin sv = 4'b0110; mv = 0; cin = 1; end
      4'h3: begin sv = 4'b0110; mv = 0; cin = 0; end
      4'h4: begin sv = 4'b0000; mv = 0; cin = 1; end
      4'h5: begin sv = 4'b1111; mv = 0; cin = 0; end
      4'h6: begin sv = 4'b1100; mv = 0; cin = 0; end
      4'h7: begin sv = 4'b1111; mv = 1; cin = 0; end
      4'h8: begin sv = 4'b0000; mv = 1; cin = 0; end
      4'h9: begin sv = 4'b1011; mv = 1; cin = 0; end
      4'hA: begin sv = 4'b1110; mv = 1; cin = 0; end
      4'hB: begin sv = 4'b0110; mv = 1; cin = 0; end
      4'hC: begin sv = 4'b0100; mv = 1; cin = 0; end
      4'hD: begin sv = 4'b0001; mv = 1; cin = 0; end
      4'hE: begin sv = 4'b1001; mv = 1; cin = 0; end
      default: begin sv = 4'b1010; mv = 1; cin = 0; end
    endcase
    pv   = av | (bv & {8{sv[0]}}) | (~bv & {8{sv[1]}});
    gv   = (av & bv & {8{sv[3]}}) | (av & ~bv & {8{sv[2]}});
    sum  = {1'b0, pv} + {1'b0, gv} + {8'd0, cin};
    sum0 = {1'b0, pv} + {1'b0, gv};
    lo   = {1'b0, pv[3:0]} + {1'b0, gv[3:0]} + {4'd0, cin};
    fo   = mv ? ~(pv ^ gv) : sum[7:0];
    xo   = ~(&pv);
    yo   = ~sum0[8];
    abo  = &fo;
    c4no = ~lo[4];
    c8no = ~sum[8];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ef <= '0; ex <= 1'b1; ey <= 1'b1; eab <= 1'b0; ec4n <= 1'b1; ec8n <= 1'b1;
    end else if (!cs_n) begin
      model(opcode, a, b, mf, mx, my, mab, mc4n, mc8n);
      ef <= mf; ex <= mx; ey <= my; eab <= mab; ec4n <= mc4n; ec8n <= mc8n;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (op=%h a=%h b=%h t=%0t)", name, act, exp, opcode, a, b, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_f", f, ef);
      chk("model_x", {7'd0, x}, {7'd0, ex});
      chk("model_y", {7'd0, y}, {7'd0, ey});
      chk("model_a_b", {7'd0, a_b}, {7'd0, eab});
      chk("model_cn4_n", {7'd0, cn4_n}, {7'd0, ec4n});
      chk("model_cn8_n", {7'd0, cn8_n}, {7'd0, ec8n});
    end
  end

  task automatic apply(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv, input logic csn);
    @(posedge clk);
    #2;
    opcode = op; a = av; b = bv; cs_n = csn;
  endtask

  // Drive one operation and sample the registered result just after the loading edge
  task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    apply(op, av, bv, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_f"}, f, 8'h00);
    chk({tag, "_x"}, {7'd0, x}, 8'h01);
    chk({tag, "_y"}, {7'd0, y}, 8'h01);
    chk({tag, "_a_b"}, {7'd0, a_b}, 8'h00);
    chk({tag, "_cn4_n"}, {7'd0, cn4_n}, 8'h01);
    chk({tag, "_cn8_n"}, {7'd0, cn8_n}, 8'h01);
  endtask

  logic [7:0] pa [6];
  logic [7:0] pb [6];

  initial begin
    rst = 1'b1; cs_n = 1'b0;
    opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    #3;
    chk_reset_vals("reset_async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk_on = 1'b1;

    run_op(4'h0, 8'h3C, 8'h0F);
    chk("add_f", f, 8'h4B);
    chk("add_cn4_n", {7'd0, cn4_n}, 8'h00);
    chk("add_cn8_n", {7'd0, cn8_n}, 8'h01);

    run_op(4'h0, 8'hFF, 8'h01);
    chk("addwrap_f", f, 8'h00);
    chk("addwrap_cn4_n", {7'd0, cn4_n}, 8'h00);
    chk("addwrap_cn8_n", {7'd0, cn8_n}, 8'h00);

    run_op(4'h2, 8'h50, 8'h20);
    chk("sub_f", f, 8'h30);
    chk("sub_cn4_n", {7'd0, cn4_n}, 8'h00);
    chk("sub_cn8_n", {7'd0, cn8_n}, 8'h00);

    run_op(4'h3, 8'h5A, 8'h5A);
    chk("subd_f", f, 8'hFF);
    chk("subd_a_b", {7'd0, a_b}, 8'h01);

    run_op(4'h4, 8'hFF, 8'h00);
    chk("inc_f", f, 8'h00);
    chk("inc_cn8_n", {7'd0, cn8_n}, 8'h00);

    run_op(4'hB, 8'hF0, 8'h3C);
    for (int k = 0; k < 4; k++) begin
      chk("xor_hold_f", f, 8'hCC);
      chk("xor_hold_x", {7'd0, x}, 8'h01);
      chk("xor_hold_y", {7'd0, y}, 8'h00);
      chk("xor_hold_a_b", {7'd0, a_b}, 8'h00);
      chk("xor_hold_cn4_n", {7'd0, cn4_n}, 8'h01);
      chk("xor_hold_cn8_n", {7'd0, cn8_n}, 8'h00);
      if (k < 3) begin
        apply(4'h0, 8'h11, 8'h22, 1'b1);
        @(posedge clk);
        #1;
      end
    end

    pa[0] = 8'h3C; pb[0] = 8'h0F;
    pa[1] = 8'hFF; pb[1] = 8'h01;
    pa[2] = 8'h50; pb[2] = 8'h20;
    pa[3] = 8'h5A; pb[3] = 8'h5A;
    pa[4] = 8'h00; pb[4] = 8'h00;
    pa[5] = 8'hA5; pb[5] = 8'hC3;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 6; k++) begin
        apply(4'(op), pa[k], pb[k], ((op + k) % 5 == 4) ? 1'b1 : 1'b0);
      end
    end

    run_op(4'h1, 8'h12, 8'h34);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("reset_mid");
    cs_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("reset_prio");
    #1;
    rst = 1'b0;

    for (int k = 0; k < 40; k++) begin
      apply(4'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mx_alu_181.md
MX_ALU_181 -- requirements
Module: mx_alu_181

Interface
REQ-001 Parameters: none; data width fixed at 8 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cs_n  input  1  chip select, active-low; 1 = hold all outputs.
REQ-005 opcode  input  4  operation select (REQ-009 table).
REQ-006 a, b  input  8 each  operands.
REQ-007 f  output  8  registered result.
REQ-008 x, y, a_b, cn4_n, cn8_n  output  1 each  registered status:
- x: group propagate, active-low.
- y: group generate, active-low.
- a_b: equality, 1 when f = 0xFF.
- cn4_n: carry out of bit 3, active-low.
- cn8_n: carry out of bit 7, active-low.

Function
REQ-009 Decode ROM maps opcode to internal (S[3:0], M, Cn_n):
- 0 ADD 1001,0,1 (A+B)
- 1 ADDI 1001,0,0 (A+B+1)
- 2 SUB 0110,0,0 (A-B)
- 3 SUBD 0110,0,1 (A-B-1)
- 4 INC 0000,0,0 (A+1)
- 5 DEC 1111,0,1 (A-1)
- 6 DBL 1100,0,1 (A+A)
- 7 PASSA 1111,1,x (A)
- 8 NOTA 0000,1,x (~A)
- 9 AND 1011,1,x
- A OR 1110,1,x
- B XOR 0110,1,x
- C NAND 0100,1,x
- D NOR 0001,1,x
- E XNOR 1001,1,x
- F PASSB 1010,1,x (B)
- x entries: Cn_n = 1.
REQ-010 Per bit i: P_i = A_i | (B_i & S0) | (~B_i & S1); G_i = (A_i & B_i & S3) | (A_i & ~B_i & S2).
REQ-011 cin = ~Cn_n; carry chain c0 = cin, c(i+1) = G_i | (P_i & c_i), i = 0..7.
REQ-012 M=0 (arithmetic): F = (P + G + cin) mod 256; equivalently F_i = P_i ^ G_i ^ c_i.
REQ-013 M=1 (logic): F_i = ~(P_i ^ G_i); the carry chain has no effect on F.
REQ-014 Next-state flags, computed in both modes:
- cn4_n = ~c4; cn8_n = ~c8.
- x = ~(&P[7:0]).
- y = ~(c8 evaluated with cin = 0).
- a_b = &F.
REQ-015 Rising clk with cs_n=0 and rst=0: all outputs load the REQ-012..014 values; latency exactly 1 cycle.
REQ-016 Rising clk with cs_n=1: all outputs hold; the ROM and datapath remain purely combinational.
REQ-017 Subtraction convention: cn8_n=0 means no borrow (A >= B for SUB); for SUBD, A=B gives f=0xFF, a_b=1.
REQ-018 Overflow wraps modulo 256; there is no saturation and no signed overflow flag.

Reset
REQ-019 rst=1 forces f=0x00, x=1, y=1, a_b=0, cn4_n=1, cn8_n=1 immediately, independent of clk.
REQ-020 Release is synchronous to the next rising clk; the first load occurs on the first edge with rst=0 and cs_n=0.
REQ-021 rst asserted mid-operation discards the pending result; rst has priority over cs_n.

Verification
REQ-022 Bench SHALL cover:
- Reset: rst=1 with random a/b/opcode -> f=00, a_b=0, x=y=cn4_n=cn8_n=1 without a clock edge.
- ADD (op 0): a=3C, b=0F -> next cycle f=4B, cn4_n=0, cn8_n=1.
- ADD wrap (op 0): a=FF, b=01 -> f=00, cn4_n=0, cn8_n=0.
- SUB (op 2): a=50, b=20 -> f=30, cn4_n=0, cn8_n=0 (no borrow).
- SUBD compare (op 3): a=b=5A -> f=FF, a_b=1.
- XOR then hold: op B, a=F0, b=3C -> f=CC; then cs_n=1 with op 0 for 3 cycles -> f remains CC and all flags unchanged.
